// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin share of one RAM among CPUS icache/dcache ports (CLK/RST; iREN/dREN/dWEN/iaddr/daddr/dstore in, iwait/dwait/iload/dload out; ramREN/ramWEN/ramaddr/ramstore out, ramload/ramstate in; arb_timeout sticky)
module memory_arbiter #(
  parameter int CPUS = 2,
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS*WIDTH-1:0] iaddr,
  input  logic [CPUS*WIDTH-1:0] daddr,
  input  logic [CPUS*WIDTH-1:0] dstore,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS*WIDTH-1:0] iload,
  output logic [CPUS*WIDTH-1:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [WIDTH-1:0]      ramaddr,
  output logic [WIDTH-1:0]      ramstore,
  input  logic [WIDTH-1:0]      ramload,
  input  logic [1:0]            ramstate,
  output logic                  arb_timeout
);
  localparam int N = 2 * CPUS;
  localparam int GW = $clog2(N);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [GW-1:0] gnt, last_grant, pick;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] req;
  logic gnt_req, access, busy, done;
  logic sel_dren, sel_dwen, sel_iren;
  logic [WIDTH-1:0] sel_daddr, sel_iaddr, sel_dstore;
  int best;
  for (genvar c = 0; c < CPUS; c++) begin : g_req
    assign req[2*c] = dREN[c] | dWEN[c];
    assign req[2*c+1] = iREN[c];
  end
  assign access = ramstate == 2'd2;
  assign busy = state == BUSY;
  assign done = busy && gnt_req && access;
  assign cnt_n = cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
  assign state_n = !busy ? (|req ? BUSY : IDLE) : (gnt_req && !access ? BUSY : IDLE);
  // closest active requestor in upward circular distance from last_grant+1
  always_comb begin
    pick = last_grant;
    best = N;
    for (int r = 0; r < N; r++)
      if (req[r] && (r + N - int'(last_grant) - 1) % N < best) begin
        best = (r + N - int'(last_grant) - 1) % N;
        pick = GW'(r);
      end
  end
  always_comb begin
    gnt_req = 1'b0;
    sel_dren = 1'b0;
    sel_dwen = 1'b0;
    sel_iren = 1'b0;
    sel_daddr = '0;
    sel_iaddr = '0;
    sel_dstore = '0;
    for (int r = 0; r < N; r++)
      if (GW'(r) == gnt) gnt_req = req[r];
    for (int c = 0; c < CPUS; c++)
      if (GW'(c) == gnt >> 1) begin
        sel_dren = dREN[c];
        sel_dwen = dWEN[c];
        sel_iren = iREN[c];
        sel_daddr = daddr[c*WIDTH +: WIDTH];
        sel_iaddr = iaddr[c*WIDTH +: WIDTH];
        sel_dstore = dstore[c*WIDTH +: WIDTH];
      end
  end
  // odd grant index is an icache; a dcache with both enables is a write
  assign ramWEN = busy && !gnt[0] && sel_dwen;
  assign ramREN = busy && (gnt[0] ? sel_iren : sel_dren && !sel_dwen);
  assign ramaddr = !busy ? '0 : gnt[0] ? sel_iaddr : sel_daddr;
  assign ramstore = ramWEN ? sel_dstore : '0;
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    for (int c = 0; c < CPUS; c++)
      if (done && GW'(c) == gnt >> 1) begin
        if (gnt[0]) begin
          iwait[c] = 1'b0;
          iload[c*WIDTH +: WIDTH] = ramload;
        end else begin
          dwait[c] = 1'b0;
          dload[c*WIDTH +: WIDTH] = ramload;
        end
      end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt <= '0;
      last_grant <= GW'(N - 1);
      cnt <= '0;
      arb_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (!busy && |req) begin
        gnt <= pick;
        cnt <= '0;
      end
      if (busy && !access) begin
        cnt <= cnt_n;
        arb_timeout <= arb_timeout | (cnt_n == CW'(TIMEOUT));
      end
      if (busy && state_n == IDLE) last_grant <= gnt;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table plus randomized run against a behavioural arbiter model
module tb_memory_arbiter;
  localparam int C = 2, W = 32, N = 4, TO = 4;
  localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2;
  localparam logic [63:0] D0 = 64'h0000_0000_DEAD_BEEF, D1 = 64'hDEAD_BEEF_0000_0000;
  logic CLK = 0, RST = 1;
  logic [C-1:0] iREN = 0, dREN = 0, dWEN = 0;
  logic [C*W-1:0] iaddr, daddr, dstore;
  logic [C-1:0] iwait, dwait;
  logic [C*W-1:0] iload, dload;
  logic ramREN, ramWEN, arb_timeout;
  logic [W-1:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate = 0;
  int tests = 0, fails = 0;
  typedef struct {
    logic rst;
    logic [1:0] ir, dr, dw, rs, ewd, ewi;
    logic eren, ewen, eto;
    logic [31:0] ea, es;
    logic [63:0] edl, eil;
  } vec_t;
  vec_t tbl[$];
  bit m_busy, m_flag;
  int m_g, m_last = N - 1, m_cnt;
  logic [1:0] e_dw, e_iw;
  logic e_ren, e_wen;
  logic [31:0] e_addr, e_st;
  logic [63:0] e_dl, e_il;

  always #5 CLK = ~CLK;

  memory_arbiter #(.CPUS(C), .WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_timeout(arb_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic [1:0] ir, dr, dw, rs, ewd, ewi,
                             input logic eren, ewen, input logic [31:0] ea, es,
                             input logic [63:0] edl, eil, input logic eto);
    vec_t t;
    t.rst = r; t.ir = ir; t.dr = dr; t.dw = dw; t.rs = rs; t.ewd = ewd; t.ewi = ewi;
    t.eren = eren; t.ewen = ewen; t.ea = ea; t.es = es; t.edl = edl; t.eil = eil; t.eto = eto;
    return t;
  endfunction

  function automatic vec_t idle(input logic r, input logic [1:0] ir, dr, dw, rs, input logic eto);
    return v(r, ir, dr, dw, rs, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, eto);
  endfunction

  function automatic bit active(input int r);
    return r % 2 == 1 ? iREN[r/2] : (dREN[r/2] | dWEN[r/2]);
  endfunction

  task automatic model_out;
    int c;
    e_dw = '1; e_iw = '1; e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0; e_dl = 0; e_il = 0;
    if (m_busy) begin
      c = m_g / 2;
      if (m_g % 2 == 0) begin
        e_wen = dWEN[c];
        e_ren = dREN[c] && !dWEN[c];
        e_addr = daddr[c*W +: W];
        e_st = dWEN[c] ? dstore[c*W +: W] : 0;
      end else begin
        e_ren = iREN[c];
        e_addr = iaddr[c*W +: W];
      end
      if (active(m_g) && ramstate == A) begin
        if (m_g % 2 == 0) begin
          e_dw[c] = 0;
          e_dl[c*W +: W] = ramload;
        end else begin
          e_iw[c] = 0;
          e_il[c*W +: W] = ramload;
        end
      end
    end
  endtask

  task automatic model_step;
    if (RST) begin
      m_busy = 0; m_last = N - 1; m_cnt = 0; m_flag = 0;
    end else if (!m_busy) begin
      for (int k = N; k >= 1; k--)
        if (active((m_last + k) % N)) begin
          m_busy = 1;
          m_g = (m_last + k) % N;
          m_cnt = 0;
        end
    end else begin
      if (ramstate != A) begin
        m_cnt++;
        if (m_cnt >= TO) m_flag = 1;
      end
      if (!active(m_g) || ramstate == A) begin
        m_busy = 0;
        m_last = m_g;
      end
    end
  endtask

  initial begin
    daddr = {32'h80, 32'h40};
    iaddr = {32'h180, 32'h100};
    dstore = {32'h1234, 32'h5555};
    ramload = 32'hDEADBEEF;
    tbl.push_back(idle(1, 0, 0, 0, F, 0));
    tbl.push_back(idle(0, 0, 2'b01, 0, F, 0));
    tbl.push_back(v(0, 0, 2'b01, 0, A, 2'b10, 2'b11, 1, 0, 32'h40, 0, D0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, F, 0));
    tbl.push_back(idle(0, 0, 0, 0, F, 0));
    tbl.push_back(idle(1, 0, 0, 0, F, 0));
    tbl.push_back(idle(0, 2'b11, 2'b11, 0, A, 0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, A, 2'b10, 2'b11, 1, 0, 32'h40, 0, D0, 0, 0));
    tbl.push_back(idle(0, 2'b11, 2'b11, 0, A, 0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, A, 2'b11, 2'b10, 1, 0, 32'h100, 0, 0, D0, 0));
    tbl.push_back(idle(0, 2'b11, 2'b11, 0, A, 0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, A, 2'b01, 2'b11, 1, 0, 32'h80, 0, D1, 0, 0));
    tbl.push_back(idle(0, 2'b11, 2'b11, 0, A, 0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, A, 2'b11, 2'b01, 1, 0, 32'h180, 0, 0, D1, 0));
    tbl.push_back(idle(0, 2'b11, 2'b11, 0, A, 0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, A, 2'b10, 2'b11, 1, 0, 32'h40, 0, D0, 0, 0));
    tbl.push_back(idle(0, 0, 2'b10, 2'b10, B, 0));
    tbl.push_back(v(0, 0, 2'b10, 2'b10, B, 2'b11, 2'b11, 0, 1, 32'h80, 32'h1234, 0, 0, 0));
    tbl.push_back(v(0, 0, 2'b10, 2'b10, B, 2'b11, 2'b11, 0, 1, 32'h80, 32'h1234, 0, 0, 0));
    tbl.push_back(v(0, 0, 2'b10, 2'b10, A, 2'b01, 2'b11, 0, 1, 32'h80, 32'h1234, D1, 0, 0));
    tbl.push_back(idle(0, 2'b01, 0, 0, B, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, 2'b01, 0, 0, B, 2'b11, 2'b11, 1, 0, 32'h100, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b01, 0, 0, B, 2'b11, 2'b11, 1, 0, 32'h100, 0, 0, 0, 1));
    tbl.push_back(v(0, 2'b01, 0, 0, A, 2'b11, 2'b10, 1, 0, 32'h100, 0, 0, D0, 1));
    tbl.push_back(idle(0, 0, 0, 0, F, 1));
    tbl.push_back(idle(0, 2'b10, 0, 0, B, 1));
    tbl.push_back(v(0, 2'b10, 0, 0, B, 2'b11, 2'b11, 1, 0, 32'h180, 0, 0, 0, 1));
    tbl.push_back(v(1, 2'b10, 0, 0, B, 2'b11, 2'b11, 1, 0, 32'h180, 0, 0, 0, 1));
    tbl.push_back(idle(0, 2'b11, 2'b11, 0, A, 0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, A, 2'b10, 2'b11, 1, 0, 32'h40, 0, D0, 0, 0));
    tbl.push_back(idle(0, 2'b01, 2'b01, 0, F, 0));
    tbl.push_back(v(0, 0, 2'b01, 0, A, 2'b11, 2'b11, 0, 0, 32'h100, 0, 0, 0, 0));
    tbl.push_back(idle(0, 2'b01, 2'b11, 0, F, 0));
    tbl.push_back(v(0, 2'b01, 2'b11, 0, A, 2'b01, 2'b11, 1, 0, 32'h80, 0, D1, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, F, 0));
    @(posedge CLK);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; iREN = tbl[i].ir; dREN = tbl[i].dr; dWEN = tbl[i].dw; ramstate = tbl[i].rs;
      @(negedge CLK);
      check($sformatf("row%0d dwait", i), dwait, tbl[i].ewd);
      check($sformatf("row%0d iwait", i), iwait, tbl[i].ewi);
      check($sformatf("row%0d ramREN", i), ramREN, tbl[i].eren);
      check($sformatf("row%0d ramWEN", i), ramWEN, tbl[i].ewen);
      check($sformatf("row%0d ramaddr", i), ramaddr, tbl[i].ea);
      check($sformatf("row%0d ramstore", i), ramstore, tbl[i].es);
      check($sformatf("row%0d dload", i), dload, tbl[i].edl);
      check($sformatf("row%0d iload", i), iload, tbl[i].eil);
      check($sformatf("row%0d arb_timeout", i), arb_timeout, tbl[i].eto);
      @(posedge CLK);
      #1;
    end
    for (int i = 0; i < 1500; i++) begin
      RST = i == 0 || $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 2) == 0) iREN = 2'($urandom);
      if ($urandom_range(0, 2) == 0) dREN = 2'($urandom);
      if ($urandom_range(0, 3) == 0) dWEN = $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b00;
      ramstate = 2'($urandom_range(0, 3));
      iaddr = {$urandom, $urandom};
      daddr = {$urandom, $urandom};
      dstore = {$urandom, $urandom};
      ramload = $urandom;
      @(negedge CLK);
      model_out();
      check($sformatf("rnd%0d dwait", i), dwait, e_dw);
      check($sformatf("rnd%0d iwait", i), iwait, e_iw);
      check($sformatf("rnd%0d ramREN", i), ramREN, e_ren);
      check($sformatf("rnd%0d ramWEN", i), ramWEN, e_wen);
      check($sformatf("rnd%0d ramaddr", i), ramaddr, e_addr);
      check($sformatf("rnd%0d ramstore", i), ramstore, e_st);
      check($sformatf("rnd%0d dload", i), dload, e_dl);
      check($sformatf("rnd%0d iload", i), iload, e_il);
      check($sformatf("rnd%0d arb_timeout", i), arb_timeout, m_flag);
      @(posedge CLK);
      model_step();
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter CPUS, default 2: number of CPUs, each with one icache and one dcache port; legal range 1-8.
REQ-002 Parameter WIDTH, default 32: address and data width.
REQ-003 Parameter TIMEOUT, default 255: maximum BUSY cycles before the timeout flag sets.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 iREN  in  CPUS  icache read request, one bit per CPU.
REQ-007 dREN / dWEN  in  CPUS each  dcache read / write request, one bit per CPU.
REQ-008 iaddr / daddr / dstore  in  CPUS*WIDTH each  per-CPU address and store data, CPU c at bits [c*WIDTH +: WIDTH].
REQ-009 iwait / dwait  out  CPUS each  active-high stall per port.
REQ-010 iload / dload  out  CPUS*WIDTH each  per-port load data.
REQ-011 ramREN / ramWEN  out  1 each  RAM read / write enable.
REQ-012 ramaddr / ramstore  out  WIDTH each  RAM address and write data.
REQ-013 ramload  in  WIDTH  RAM read data.
REQ-014 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-015 arb_timeout  out  1  sticky flag: a grant exceeded TIMEOUT BUSY cycles.

Function
REQ-016 Requestors SHALL be indexed r = 0..2*CPUS-1: r = 2c is dcache of CPU c, r = 2c+1 is icache of CPU c; dcache requests when dREN or dWEN is high, icache when iREN is high.
REQ-017 The FSM SHALL have two states, IDLE and BUSY.
REQ-018 IDLE: if any requestor is active, the block SHALL latch a grant index and enter BUSY on the next edge; otherwise it stays in IDLE.
REQ-019 Grant choice SHALL be round-robin: first active requestor searching upward, modulo 2*CPUS, from (last_grant+1); last_grant resets to 2*CPUS-1, so r=0 wins first.
REQ-020 In BUSY, RAM outputs SHALL come only from the granted requestor: ramWEN = dWEN; ramREN = dREN & ~dWEN for dcache, iREN for icache; ramaddr from daddr/iaddr; ramstore = dstore on writes, else 0.
REQ-021 If dWEN and dREN are both high on a granted dcache, it SHALL be treated as a write.
REQ-022 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL be 0.
REQ-023 In BUSY with ramstate==ACCESS, the granted port's wait SHALL be 0 for that cycle, its load SHALL equal ramload, last_grant SHALL update, and the FSM SHALL return to IDLE next edge.
REQ-024 All non-granted ports SHALL have wait=1 and load=0 every cycle; the granted port also has wait=1 and load=0 except on its ACCESS cycle.
REQ-025 If the granted request drops while in BUSY, the FSM SHALL return to IDLE next edge with no wait deassertion; last_grant still updates.
REQ-026 Minimum latency SHALL be 2 cycles from request to wait=0: grant on edge 1, ACCESS completion on edge 2 at the earliest; one IDLE cycle separates consecutive grants.
REQ-027 ramstate==ERROR in BUSY SHALL be treated like BUSY: hold the grant and keep wait=1.
REQ-028 A counter of width clog2(TIMEOUT+1) SHALL clear on every grant and increment each BUSY cycle without ACCESS, saturating at TIMEOUT.
REQ-029 When the counter reaches TIMEOUT, arb_timeout SHALL set and stay set until reset; the grant is not aborted.
REQ-030 The grant index SHALL be stable for the whole BUSY period regardless of new requests.

Reset
REQ-031 With RST high at an edge, the FSM SHALL go to IDLE, last_grant to 2*CPUS-1, counter to 0, arb_timeout to 0; all waits 1, loads 0, RAM outputs 0 from that edge on.
REQ-032 Reset mid-BUSY SHALL abandon the transaction without any wait=0 pulse.

Verification
REQ-033 CPUS=2; CPU0 dREN with daddr=0x40; ramstate=ACCESS on the 2nd cycle, ramload=0xDEADBEEF -> dwait[0]=0 and dload[0]=0xDEADBEEF for exactly one cycle; all other waits 1.
REQ-034 All four requestors held high, ACCESS every BUSY cycle -> grants in order r=0,1,2,3,0, one IDLE cycle between each.
REQ-035 CPU1 dWEN=dREN=1, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234 while granted.
REQ-036 TIMEOUT=4, ramstate held BUSY -> arb_timeout rises after 4 BUSY cycles, grant held, flag persists after a later ACCESS.
REQ-037 Reset asserted in BUSY one cycle before ACCESS -> no wait=0 pulse; r=0 wins the next grant.
